// File: rtl/nlp16af_pkg.sv
// Shared NLP-16AF definitions used by the fetch unit and the decoder.
// Holds the opcode values that set instruction length and the fetch FSM states.
package nlp16af_pkg;

    localparam logic [3:0] OP_PUSH   = 4'hD;
    localparam logic [3:0] OP_POP    = 4'hC;
    localparam logic [3:0] IMM_FIELD = 4'h3;

    typedef enum logic [1:0] {
        F1,
        F2,
        F3,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/nlp16af_inst_len.sv
// Instruction length classifier. The decoder reuses it, so it is kept separate from the fetch unit.
// A push or pop opcode is a 1-word instruction; an IMM_FIELD in ir2 adds a third word.
module nlp16af_inst_len
    import nlp16af_pkg::*;
(
    input  logic [15:0] ir1_i,
    input  logic [15:0] ir2_i,
    output logic        one_word_o,
    output logic        needs_imm_o
);

    logic unused_bits;

    always_comb begin
        one_word_o  = (ir1_i[15:12] == OP_PUSH) || (ir1_i[15:12] == OP_POP);
        needs_imm_o = (ir2_i[15:12] == IMM_FIELD) || (ir2_i[11:8] == IMM_FIELD);
        unused_bits = ^{ir1_i[11:0], ir2_i[7:0]};
    end

endmodule

// File: rtl/nlp16af_fetch_unit.sv
// NLP-16AF instruction fetch unit. It reads 1-3 words per instruction over req/ack, then
// holds the instruction for the decoder over valid/ready and handles execute-stage redirects.
module nlp16af_fetch_unit
    import nlp16af_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_ir1,
    output logic [15:0] o_ir2,
    output logic [15:0] o_ir3,
    output logic [1:0]  o_len,
    output logic [15:0] o_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pend_pc_q, pend_pc_d;
    logic         pend_q, pend_d;
    logic [15:0]  ir1_q, ir1_d;
    logic [15:0]  ir2_q, ir2_d;
    logic [15:0]  ir3_q, ir3_d;
    logic [1:0]   len_q, len_d;
    logic         one_word;
    logic         needs_imm;

    // Read data is only classified in the state where it is the relevant word.
    nlp16af_inst_len u_inst_len (
        .ir1_i       (i_mem_rdata),
        .ir2_i       (i_mem_rdata),
        .one_word_o  (one_word),
        .needs_imm_o (needs_imm)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pend_d    = pend_q;
        ir1_d     = ir1_q;
        ir2_d     = ir2_q;
        ir3_d     = ir3_q;
        len_d     = len_q;

        if (state_q == HOLD) begin
            if (i_redirect) begin
                pc_d    = i_redirect_pc;
                state_d = F1;
            end else if (i_ready) begin
                pc_d    = pc_q + {14'b0, len_q};
                ir2_d   = 16'h0000;
                ir3_d   = 16'h0000;
                state_d = F1;
            end
        end else if (i_mem_ack) begin
            if (i_redirect || pend_q) begin
                // A redirect seen this cycle is newer than any latched one.
                pc_d    = i_redirect ? i_redirect_pc : pend_pc_q;
                pend_d  = 1'b0;
                state_d = F1;
            end else begin
                unique case (state_q)
                    F1: begin
                        ir1_d = i_mem_rdata;
                        ir2_d = 16'h0000;
                        ir3_d = 16'h0000;
                        if (one_word) begin
                            len_d   = 2'd1;
                            state_d = HOLD;
                        end else begin
                            state_d = F2;
                        end
                    end
                    F2: begin
                        ir2_d = i_mem_rdata;
                        if (needs_imm) begin
                            state_d = F3;
                        end else begin
                            len_d   = 2'd2;
                            state_d = HOLD;
                        end
                    end
                    F3: begin
                        ir3_d   = i_mem_rdata;
                        len_d   = 2'd3;
                        state_d = HOLD;
                    end
                    default: state_d = F1;
                endcase
            end
        end else if (i_redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = i_redirect_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= F1;
            pc_q      <= RESET_PC;
            pend_pc_q <= 16'h0000;
            pend_q    <= 1'b0;
            ir1_q     <= 16'h0000;
            ir2_q     <= 16'h0000;
            ir3_q     <= 16'h0000;
            len_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            ir1_q     <= ir1_d;
            ir2_q     <= ir2_d;
            ir3_q     <= ir3_d;
            len_q     <= len_d;
        end
    end

    always_comb begin
        unique case (state_q)
            F2:      o_mem_addr = pc_q + 16'd1;
            F3:      o_mem_addr = pc_q + 16'd2;
            default: o_mem_addr = pc_q;
        endcase
        // Gated by reset so no request is seen while reset is held.
        o_mem_req = (state_q != HOLD) && !i_rst;
        o_valid   = (state_q == HOLD);
        o_ir1     = ir1_q;
        o_ir2     = ir2_q;
        o_ir3     = ir3_q;
        o_len     = len_q;
        o_pc      = pc_q;
    end

endmodule

// File: tb/tb_nlp16af_fetch_unit.sv
// Self-checking bench for nlp16af_fetch_unit: directed scenarios, then random memory latency,
// random redirects and random program contents checked against an instruction-level model.
module tb_nlp16af_fetch_unit;

    logic        i_clk;
    logic        i_rst;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_ir1;
    logic [15:0] o_ir2;
    logic [15:0] o_ir3;
    logic [1:0]  o_len;
    logic [15:0] o_pc;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;

    nlp16af_fetch_unit #(
        .RESET_PC (16'h0000)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_ir1         (o_ir1),
        .o_ir2         (o_ir2),
        .o_ir3         (o_ir3),
        .o_len         (o_len),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    logic [15:0] mem [0:65535];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [15:0] model_pc;
    bit          mem_rand  = 0;
    bit          delay_en  = 0;
    logic [15:0] delay_addr = 16'h0000;

    int          m_cnt   = 0;
    int          m_delay = 0;
    bit          m_outst = 0;
    logic [15:0] m_addr  = 16'h0000;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: acks at the negedge for the following posedge; also watches request stability.
    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = 16'h0000;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                i_mem_ack = 1'b0;
                m_cnt     = 0;
                m_outst   = 0;
            end else begin
                if (m_outst) begin
                    chk("req_held", 32'(o_mem_req), 32'd1);
                    chk("addr_held", 32'(o_mem_addr), 32'(m_addr));
                end
                if (o_mem_req) begin
                    if (m_cnt == 0) begin
                        if (mem_rand) m_delay = $urandom_range(0, 2);
                        else m_delay = (delay_en && o_mem_addr == delay_addr) ? 3 : 0;
                    end
                    if (m_cnt >= m_delay) begin
                        i_mem_ack   = 1'b1;
                        i_mem_rdata = mem[o_mem_addr];
                        m_cnt       = 0;
                        m_outst     = 0;
                    end else begin
                        i_mem_ack = 1'b0;
                        m_cnt++;
                        m_outst   = 1;
                        m_addr    = o_mem_addr;
                    end
                end else begin
                    i_mem_ack = 1'b0;
                    m_cnt     = 0;
                    m_outst   = 0;
                end
            end
        end
    end

    // Instruction-level reference: what the decoder should see for an instruction at pc.
    function automatic void ref_instr(input logic [15:0] pc, output logic [15:0] e1,
                                      output logic [15:0] e2, output logic [15:0] e3,
                                      output logic [1:0] el);
        logic [15:0] w2;
        e1 = mem[pc];
        e2 = 16'h0000;
        e3 = 16'h0000;
        el = 2'd1;
        if (e1[15:12] != 4'hD && e1[15:12] != 4'hC) begin
            w2 = mem[pc + 16'd1];
            e2 = w2;
            el = 2'd2;
            if (w2[15:12] == 4'h3 || w2[11:8] == 4'h3) begin
                el = 2'd3;
                e3 = mem[pc + 16'd2];
            end
        end
    endfunction

    task automatic wait_valid(input bit rand_redir, output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 200) begin
            if (rand_redir && $urandom_range(0, 9) == 0) begin
                i_redirect    = 1'b1;
                i_redirect_pc = 16'($urandom);
                model_pc      = i_redirect_pc;
            end
            @(posedge i_clk);
            #1;
            i_redirect = 1'b0;
            cycles++;
        end
        chk("valid_timeout", 32'(o_valid), 32'd1);
    endtask

    task automatic check_hold(input logic [15:0] pc, output logic [1:0] el);
        logic [15:0] e1, e2, e3;
        ref_instr(pc, e1, e2, e3, el);
        chk("o_pc", 32'(o_pc), 32'(pc));
        chk("o_ir1", 32'(o_ir1), 32'(e1));
        chk("o_ir2", 32'(o_ir2), 32'(e2));
        chk("o_ir3", 32'(o_ir3), 32'(e3));
        chk("o_len", 32'(o_len), 32'(el));
    endtask

    task automatic accept(input logic [15:0] next_pc);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("next_addr", 32'(o_mem_addr), 32'(next_pc));
        chk("next_req", 32'(o_mem_req), 32'd1);
    endtask

    task automatic redirect_hold(input logic [15:0] tgt, input logic rdy);
        i_redirect    = 1'b1;
        i_redirect_pc = tgt;
        i_ready       = rdy;
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        i_ready    = 1'b0;
        chk("redir_valid", 32'(o_valid), 32'd0);
        chk("redir_addr", 32'(o_mem_addr), 32'(tgt));
        chk("redir_pc", 32'(o_pc), 32'(tgt));
    endtask

    // Wait for a directed instruction, check its latency and contents, then accept it.
    task automatic step(input logic [15:0] pc, input int lat, input logic [1:0] len_exp);
        int          cyc;
        logic [1:0]  el;
        wait_valid(0, cyc);
        chk("latency", 32'(cyc), 32'(lat));
        chk("len_const", 32'(o_len), 32'(len_exp));
        check_hold(pc, el);
        accept(pc + 16'(el));
    endtask

    initial begin
        int          cyc;
        int          act;
        logic [1:0]  el;
        logic [15:0] tgt;
        logic [15:0] w;

        i_rst         = 1'b1;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[16'(a)] = 16'h0000;
        mem[0]      = 16'hD100;
        mem[1]      = 16'hC000;
        mem[2]      = 16'hD000;
        mem[3]      = 16'hC111;
        mem[4]      = 16'h1012;
        mem[5]      = 16'h0120;
        mem[6]      = 16'hD000;
        mem[7]      = 16'hC000;
        mem[8]      = 16'h1000;
        mem[9]      = 16'h3100;
        mem[10]     = 16'hBEEF;
        mem[11]     = 16'h1000;
        mem[12]     = 16'h0300;
        mem[13]     = 16'h1234;
        mem[14]     = 16'hD000;
        mem[15]     = 16'h2000;
        mem[16]     = 16'h0000;
        mem[17]     = 16'h2000;
        mem[18]     = 16'h0000;
        mem[16'h30] = 16'hC030;
        mem[16'h40] = 16'hD040;
        mem[16'h50] = 16'hD050;
        mem[16'hFFFF] = 16'h2000;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ir1", 32'(o_ir1), 32'd0);
        chk("rst_len", 32'(o_len), 32'd0);
        chk("rst_pc", 32'(o_pc), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("first_req", 32'(o_mem_req), 32'd1);
        chk("first_addr", 32'(o_mem_addr), 32'd0);

        // Zero-wait sequence: lengths 1, 2 and both forms of 3.
        step(16'd0, 1, 2'd1);
        step(16'd1, 1, 2'd1);
        step(16'd2, 1, 2'd1);
        step(16'd3, 1, 2'd1);
        step(16'd4, 2, 2'd2);
        step(16'd6, 1, 2'd1);
        step(16'd7, 1, 2'd1);
        step(16'd8, 3, 2'd3);
        chk("imm_beef_seen", 32'(mem[10]), 32'h0000BEEF);
        step(16'd11, 3, 2'd3);
        step(16'd14, 1, 2'd1);

        // Ack on the second-word request delayed by 3 cycles.
        delay_en   = 1;
        delay_addr = 16'd16;
        @(posedge i_clk);
        #1;
        chk("w_addr", 32'(o_mem_addr), 32'd16);
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            chk("w_req", 32'(o_mem_req), 32'd1);
            chk("w_addr_held", 32'(o_mem_addr), 32'd16);
            chk("w_novalid", 32'(o_valid), 32'd0);
        end
        @(posedge i_clk);
        #1;
        chk("w_valid", 32'(o_valid), 32'd1);
        check_hold(16'd15, el);
        accept(16'd17);

        // Two redirects while the second-word request waits; the later target wins.
        delay_addr = 16'd18;
        @(posedge i_clk);
        #1;
        chk("r_addr", 32'(o_mem_addr), 32'd18);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0030;
        @(posedge i_clk);
        #1;
        i_redirect_pc = 16'h0040;
        @(posedge i_clk);
        #1;
        i_redirect = 1'b0;
        cyc = 0;
        while (o_mem_addr == 16'd18 && cyc < 10) begin
            chk("r_novalid", 32'(o_valid), 32'd0);
            @(posedge i_clk);
            #1;
            cyc++;
        end
        chk("r_new_addr", 32'(o_mem_addr), 32'h0040);
        chk("r_novalid2", 32'(o_valid), 32'd0);
        wait_valid(0, cyc);
        check_hold(16'h0040, el);

        // Redirect in HOLD beats a simultaneous ready.
        redirect_hold(16'h0050, 1'b1);
        wait_valid(0, cyc);
        check_hold(16'h0050, el);

        // Wrap: 2-word instruction at 16'hFFFF reads its second word from 16'h0000.
        redirect_hold(16'hFFFF, 1'b0);
        wait_valid(0, cyc);
        chk("wrap_lat", 32'(cyc), 32'd2);
        chk("wrap_ir2", 32'(o_ir2), 32'h0000D100);
        check_hold(16'hFFFF, el);
        accept(16'h0001);
        wait_valid(0, cyc);
        check_hold(16'h0001, el);

        // Reset while the immediate-word request is pending.
        delay_addr = 16'd10;
        redirect_hold(16'd8, 1'b0);
        cyc = 0;
        while (o_mem_addr != 16'd10 && cyc < 10) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        chk("f3_reached", 32'(o_mem_addr), 32'd10);
        delay_en = 0;
        i_rst    = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mrst_req", 32'(o_mem_req), 32'd0);
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_pc", 32'(o_pc), 32'd0);
        chk("mrst_len", 32'(o_len), 32'd0);
        chk("mrst_ir2", 32'(o_ir2), 32'd0);
        chk("mrst_ir3", 32'(o_ir3), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("mrst_first_addr", 32'(o_mem_addr), 32'd0);
        wait_valid(0, cyc);
        check_hold(16'd0, el);

        // Random program, random latency, random redirects.
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            act = $urandom_range(0, 3);
            if (act == 0) w[15:12] = ($urandom_range(0, 1) == 1) ? 4'hD : 4'hC;
            else if (act == 1) w[15:12] = 4'h3;
            else if (act == 2) w[11:8] = 4'h3;
            mem[16'(a)] = w;
        end
        mem_rand = 1;
        tgt = 16'($urandom);
        redirect_hold(tgt, 1'b1);
        model_pc = tgt;
        for (int k = 0; k < 150; k++) begin
            wait_valid(1, cyc);
            check_hold(model_pc, el);
            act = $urandom_range(0, 5);
            if (act == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                    @(posedge i_clk);
                    #1;
                    chk("stall_valid", 32'(o_valid), 32'd1);
                    chk("stall_pc", 32'(o_pc), 32'(model_pc));
                end
                accept(model_pc + 16'(el));
                model_pc = model_pc + 16'(el);
            end else if (act == 1) begin
                tgt = 16'($urandom);
                redirect_hold(tgt, 1'($urandom_range(0, 1)));
                model_pc = tgt;
            end else begin
                accept(model_pc + 16'(el));
                model_pc = model_pc + 16'(el);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nlp16af_fetch_unit.md
# nlp16af_fetch_unit

Instruction fetch unit for the NLP-16AF core; it produces the IR1/IR2 words that the instruction decoder consumes. It reads 1-3 sequential 16-bit words from instruction memory over a req/ack handshake, classifies instruction length from the opcode and register fields, and hands a complete instruction to the decoder over a valid/ready handshake. It advances the PC by the instruction length and restarts at a new PC on a redirect from the execute stage.

## Interface
Parameters:
- RESET_PC, 16'h0000, word address loaded into PC on reset.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  16  word address of the request.
- i_mem_ack  in  1  read completes this cycle; i_mem_rdata valid.
- i_mem_rdata  in  16  read data.
- o_valid  out  1  complete instruction on o_ir1..o_ir3.
- i_ready  in  1  decoder accepts the instruction.
- o_ir1  out  16  first word (opcode word).
- o_ir2  out  16  second word; 0 for 1-word instructions.
- o_ir3  out  16  16-bit immediate; 0 unless length 3.
- o_len  out  2  instruction length in words (1..3).
- o_pc  out  16  address of o_ir1.
- i_redirect  in  1  branch/call/return redirect strobe.
- i_redirect_pc  in  16  new fetch address.

## Operation
- States: F1, F2, F3, HOLD.
- F1: request at PC. On ack, capture IR1 and compute its opcode = ir1[15:12]:
  - 4'hD (push) or 4'hC (pop): length 1 → HOLD.
  - Otherwise → F2.
- F2: request at PC+1. On ack, capture IR2:
  - If ir2[15:12]==4'h3 or ir2[11:8]==4'h3: length 3 → F3.
  - Else: length 2 → HOLD.
- F3: request at PC+2. On ack, capture IR3 → HOLD.
- HOLD: o_valid=1 and o_ir*/o_len/o_pc are stable. On i_ready: PC ← PC+o_len (mod 2^16, wraps 16'hFFFF→16'h0000), clear o_ir2/o_ir3, → F1.
- Request rules:
  - o_mem_req is high in F1/F2/F3 only.
  - o_mem_addr and o_mem_req are held stable until ack. A request is never withdrawn.
  - Address arithmetic is 16-bit with wrap.
- Redirect:
  - i_redirect with no request outstanding (HOLD, or a fetch state whose ack arrives the same cycle): PC ← i_redirect_pc, o_valid drops next cycle, → F1. A HOLD handoff in that cycle is superseded by the redirect.
  - i_redirect while a request is pending without ack: set pend flag and latch i_redirect_pc. When the ack arrives, discard the data, load the latched PC and go → F1.
  - A later redirect before that ack overwrites the latched PC.
- Reset: state F1, PC=RESET_PC, pend=0, o_mem_req=0, o_valid=0, o_ir1/2/3=0, o_len=0, o_pc=RESET_PC. The first request issues in the first cycle after i_rst deasserts. Reset mid-transaction abandons the request; memory ignores an ack that arrives under reset.

## Timing
- Zero-wait memory (ack in the same cycle as req): length 1/2/3 instruction reaches o_valid 1/2/3 cycles after entering F1.
- Each wait cycle adds one cycle.
- Handoff cycle (valid&ready) → F1 request on the next cycle. Back-to-back throughput is len+1 cycles per instruction.
- Outputs are registered. o_valid deasserts the cycle after acceptance.
- i_ready is ignored outside HOLD.

## Structure
- Shared package nlp16af_pkg holds:
  - OP_PUSH=4'hD, OP_POP=4'hC, IMM_FIELD=4'h3.
  - Typedef fetch_state_e {F1,F2,F3,HOLD}.
- One combinational sub-module, nlp16af_inst_len. It takes ir1 and ir2 and returns 1-word/needs-imm flags. The decoder can reuse the same classification.

## Test plan
- Zero-wait, RESET_PC=0, mem[0]=16'hD100 (push): o_valid at cycle 1 with o_len=1, o_pc=0; after ready, next req addr=1.
- mem[4]=16'h1012, mem[5]=16'h0120, ready held high: o_len=2, o_ir2=16'h0120, o_ir3=0; next addr=6.
- mem[8]=16'h1000, mem[9]=16'h3100, mem[10]=16'hBEEF: o_len=3, o_ir3=16'hBEEF, next addr=11. Repeat with mem[9]=16'h0300: o_len=3.
- Ack delayed 3 cycles on the F2 request: o_mem_addr stays PC+1 and o_mem_req stays high throughout; o_valid appears 1 cycle after ack.
- i_redirect to 16'h0040 while the F2 request waits: on ack, data is discarded, next req addr=16'h0040, no o_valid for the old instruction. Redirect in HOLD with i_ready=1: redirect wins.
- PC=16'hFFFF with a 2-word instruction: second fetch addr=16'h0000, next PC=16'h0001. Assert i_rst mid-F3: o_mem_req=0, o_valid=0; first post-reset request goes to RESET_PC.
